// File: rtl/clkgate_pkg.sv
// clkgate_ctrl shared definitions: state encodings and default sizes.
// Optional CLKGATE_STATS_EN build adds a gated-cycle counter to the top.
package clkgate_pkg;

  localparam int STATE_W         = 2;
  localparam int IDLE_W_DEF      = 8;
  localparam int WAKE_CYCLES_DEF = 2;
  localparam int STAT_W_DEF      = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN   = 2'd0,
    ST_GATED = 2'd1,
    ST_WAKE  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds once cnt reaches max.
// Shared by clock-domain control blocks.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < max)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/clkgate_ctrl.sv
// Idle-driven clock gate enable with timed wake and 4-phase wake handshake.
// Build with CLKGATE_STATS_EN to add stats_clr / gated_cycles.
module clkgate_ctrl
  import clkgate_pkg::*;
#(
  parameter int IDLE_W      = IDLE_W_DEF,
  parameter int WAKE_CYCLES = WAKE_CYCLES_DEF,
  parameter int STAT_W      = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              busy,
  input  logic [IDLE_W-1:0] idle_thresh,
  input  logic              wake_req,
`ifdef CLKGATE_STATS_EN
  input  logic              stats_clr,
  output logic [STAT_W-1:0] gated_cycles,
`endif
  output logic              wake_ack,
  output logic              gate,
  output logic              gated
);

  localparam logic [7:0]      WAKE_LAST = 8'(WAKE_CYCLES - 1);
  localparam logic [IDLE_W:0] ONE       = (IDLE_W + 1)'(1);

  state_t            state;
  state_t            state_nx;
  logic [IDLE_W-1:0] idle_cnt;
  logic [7:0]        wake_cnt;
  logic              idle_s;
  logic              hit;
  logic              wake_ev;
  logic              in_run;

  assign idle_s  = en & ~busy & ~wake_req & (idle_thresh != '0);
  assign in_run  = (state == ST_RUN);
  assign wake_ev = wake_req | busy | ~en;
  // >= also covers a threshold lowered below the running count
  assign hit = idle_s &
               (({1'b0, idle_cnt} + ONE) >= {1'b0, idle_thresh});

  sat_counter #(.WIDTH(IDLE_W)) u_idle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (idle_s & in_run),
    .clr   (~idle_s | ~in_run),
    .max   (idle_thresh),
    .cnt   (idle_cnt)
  );

  always_comb begin
    state_nx = ST_RUN;
    case (state)
      ST_RUN:   state_nx = hit ? ST_GATED : ST_RUN;
      ST_GATED: state_nx = wake_ev ? ST_WAKE : ST_GATED;
      ST_WAKE:  state_nx = (wake_cnt == WAKE_LAST) ? ST_RUN : ST_WAKE;
      default:  state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      gate     <= 1'b1;
      gated    <= 1'b0;
      wake_ack <= 1'b0;
      wake_cnt <= '0;
    end else begin
      state    <= state_nx;
      gate     <= (state_nx != ST_GATED);
      gated    <= (state_nx == ST_GATED);
      wake_ack <= (state_nx == ST_RUN) & wake_req;
      wake_cnt <= ((state == ST_WAKE) && (state_nx == ST_WAKE))
                  ? wake_cnt + 8'd1 : 8'd0;
    end
  end

`ifdef CLKGATE_STATS_EN
  sat_counter #(.WIDTH(STAT_W)) u_stat (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (state == ST_GATED),
    .clr   (stats_clr),
    .max   ({STAT_W{1'b1}}),
    .cnt   (gated_cycles)
  );
`endif

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Scoreboard bench for clkgate_ctrl: each step pushes expected
// {gate,gated,wake_ack} and pops it one edge later.
module tb_clkgate_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       busy;
  logic       wake_req;
  logic       wake_ack;
  logic       gate;
  logic       gated;
  logic [7:0] idle_thresh;
`ifdef CLKGATE_STATS_EN
  logic       stats_clr;
  logic [3:0] gated_cycles;
`endif

  int total = 0;
  int bad   = 0;
  logic [2:0] sb[$];

  always #5 clk = ~clk;

`ifdef CLKGATE_STATS_EN
  clkgate_ctrl #(.IDLE_W(8), .WAKE_CYCLES(2), .STAT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .busy         (busy),
    .idle_thresh  (idle_thresh),
    .wake_req     (wake_req),
    .stats_clr    (stats_clr),
    .gated_cycles (gated_cycles),
    .wake_ack     (wake_ack),
    .gate         (gate),
    .gated        (gated)
  );
`else
  clkgate_ctrl #(.IDLE_W(8), .WAKE_CYCLES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .busy        (busy),
    .idle_thresh (idle_thresh),
    .wake_req    (wake_req),
    .wake_ack    (wake_ack),
    .gate        (gate),
    .gated       (gated)
  );
`endif

  // v = {en, busy, wake_req, exp_gate, exp_gated, exp_ack}
  task automatic step(input logic [5:0] v);
    en       = v[5];
    busy     = v[4];
    wake_req = v[3];
    sb.push_back(v[2:0]);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [2:0] x;
    rst_n = 1'b0;
    idle_thresh = 8'd4;
`ifdef CLKGATE_STATS_EN
    stats_clr = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      step(6'b110_100);
      x = sb.pop_front();
      total++;
      if ({gate, gated, wake_ack} !== x) begin
        bad++;
        $display("FAIL reset[%0d] got=%b want=%b", i, {gate, gated, wake_ack}, x);
      end
    end
`ifdef CLKGATE_STATS_EN
    total++;
    if (gated_cycles !== 4'd0) begin
      bad++;
      $display("FAIL reset_stats got=%0d want=0", gated_cycles);
    end
`endif
  endtask

  task automatic test_idle_entry;
    logic [5:0] tab [9];
    logic [2:0] x;
    tab = '{6'b110_100, 6'b100_100, 6'b100_100, 6'b110_100, 6'b100_100,
            6'b100_100, 6'b100_100, 6'b100_010, 6'b100_010};
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(tab[i]);
      x = sb.pop_front();
      total++;
      if ({gate, gated, wake_ack} !== x) begin
        bad++;
        $display("FAIL idle_entry[%0d] got=%b want=%b", i, {gate, gated, wake_ack}, x);
      end
    end
  endtask

  task automatic test_reset_mid_gated;
    logic [5:0] tab [5];
    logic [2:0] x;
    tab = '{6'b100_100, 6'b100_100, 6'b100_100, 6'b100_100, 6'b100_010};
    for (int i = 0; i < 5; i++) begin
      rst_n = (i != 0);
      step(tab[i]);
      x = sb.pop_front();
      total++;
      if ({gate, gated, wake_ack} !== x) begin
        bad++;
        $display("FAIL reset_mid[%0d] got=%b want=%b", i, {gate, gated, wake_ack}, x);
      end
    end
  endtask

  task automatic test_wake;
    logic [5:0] tab [12];
    logic [2:0] x;
    tab = '{6'b101_100, 6'b101_100, 6'b101_101, 6'b101_101, 6'b101_101,
            6'b101_101, 6'b101_101, 6'b101_101, 6'b100_100, 6'b100_100,
            6'b100_100, 6'b100_010};
    for (int i = 0; i < 12; i++) begin
      step(tab[i]);
      x = sb.pop_front();
      total++;
      if ({gate, gated, wake_ack} !== x) begin
        bad++;
        $display("FAIL wake[%0d] got=%b want=%b", i, {gate, gated, wake_ack}, x);
      end
    end
  endtask

  task automatic test_ack_in_run;
    logic [5:0] tab [9];
    logic [2:0] x;
    tab = '{6'b110_100, 6'b100_100, 6'b100_100, 6'b111_101, 6'b110_100,
            6'b100_100, 6'b100_100, 6'b100_100, 6'b100_010};
    for (int i = 0; i < 9; i++) begin
      step(tab[i]);
      x = sb.pop_front();
      total++;
      if ({gate, gated, wake_ack} !== x) begin
        bad++;
        $display("FAIL ack_run[%0d] got=%b want=%b", i, {gate, gated, wake_ack}, x);
      end
    end
  endtask

  task automatic test_en_low;
    logic [5:0] tab [13];
    logic [2:0] x;
    tab = '{6'b000_100, 6'b110_100, 6'b100_100, 6'b000_100, 6'b000_100,
            6'b000_100, 6'b000_100, 6'b000_100, 6'b000_100, 6'b100_100,
            6'b100_100, 6'b100_100, 6'b100_010};
    for (int i = 0; i < 13; i++) begin
      step(tab[i]);
      x = sb.pop_front();
      total++;
      if ({gate, gated, wake_ack} !== x) begin
        bad++;
        $display("FAIL en_low[%0d] got=%b want=%b", i, {gate, gated, wake_ack}, x);
      end
    end
  endtask

  task automatic test_thresh_one;
    logic [5:0] tab [8];
    logic [2:0] x;
    tab = '{6'b110_100, 6'b110_100, 6'b110_100, 6'b100_010,
            6'b110_100, 6'b100_100, 6'b100_100, 6'b100_010};
    idle_thresh = 8'd1;
    for (int i = 0; i < 8; i++) begin
      step(tab[i]);
      x = sb.pop_front();
      total++;
      if ({gate, gated, wake_ack} !== x) begin
        bad++;
        $display("FAIL thresh_one[%0d] got=%b want=%b", i, {gate, gated, wake_ack}, x);
      end
    end
    idle_thresh = 8'd4;
  endtask

  task automatic test_thresh_zero;
    logic [2:0] x;
    idle_thresh = 8'd0;
    for (int i = 0; i < 1007; i++) begin
      if (i == 1003) idle_thresh = 8'd4;
      if (i == 0) step(6'b110_100);
      else if (i == 1006) step(6'b100_010);
      else step(6'b100_100);
      x = sb.pop_front();
      total++;
      if ({gate, gated, wake_ack} !== x) begin
        bad++;
        $display("FAIL thresh_zero[%0d] got=%b want=%b", i, {gate, gated, wake_ack}, x);
      end
    end
  endtask

  task automatic test_tie;
    logic [5:0] tab [11];
    logic [2:0] x;
    tab = '{6'b110_100, 6'b100_100, 6'b100_100, 6'b100_100, 6'b100_100,
            6'b100_100, 6'b110_100, 6'b100_100, 6'b100_100, 6'b100_100,
            6'b100_010};
    for (int i = 0; i < 11; i++) begin
      step(tab[i]);
      x = sb.pop_front();
      total++;
      if ({gate, gated, wake_ack} !== x) begin
        bad++;
        $display("FAIL tie[%0d] got=%b want=%b", i, {gate, gated, wake_ack}, x);
      end
    end
  endtask

`ifdef CLKGATE_STATS_EN
  task automatic test_stats;
    logic [2:0] x;
    for (int i = 0; i < 32; i++) begin
      stats_clr = (i == 0) || (i == 11);
      step(6'b100_010);
      x = sb.pop_front();
      total++;
      if ({gate, gated, wake_ack} !== x) begin
        bad++;
        $display("FAIL stats_state[%0d] got=%b want=%b", i, {gate, gated, wake_ack}, x);
      end
      if (i == 0 || i == 10 || i == 11 || i == 31) begin
        total++;
        if (gated_cycles !== ((i == 10) ? 4'd10 : (i == 31) ? 4'd15 : 4'd0)) begin
          bad++;
          $display("FAIL stats[%0d] got=%0d", i, gated_cycles);
        end
      end
    end
    stats_clr = 1'b0;
  endtask
`endif

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    busy     = 1'b1;
    wake_req = 1'b0;
    test_reset();
    test_idle_entry();
    test_reset_mid_gated();
    test_wake();
    test_ack_in_run();
    test_en_low();
    test_thresh_one();
    test_thresh_zero();
    test_tie();
`ifdef CLKGATE_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
